rr_mux_2x1_arb: RTL and testbench

- Upstream control and buffering stage for the 2:1 data mux.
- Arbitrates between two valid/ready sources (d1, d2) using round-robin and holds the winner in a one-entry output register.
- Presents the winning data on y, and the matching select on s, to the downstream consumer.
- Adds flow control and fairness to the plain combinational 2:1 selection.

---
 rtl/rr_mux_2x1_arb.sv | 139 +++++++++++++
 tb/tb_rr_mux_2x1_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_2x1_arb.sv
// rr_mux_2x1_arb: round-robin arbiter between two valid/ready sources that
// feeds a one-entry output register. The held word is presented on y with
// its source select on s; a drain and a load may happen in the same cycle,
// so a continuously ready consumer sees one word per clock.
module rr_mux_2x1_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d1_valid,
  input  logic [WIDTH-1:0] d1,
  output logic             d1_ready,
  input  logic             d2_valid,
  input  logic [WIDTH-1:0] d2,
  output logic             d2_ready,
  output logic             s,
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  input  logic             y_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_d;
  logic               s_q;
  logic               s_d;
  // Index of the source that won the most recent load: 0 = d1, 1 = d2.
  logic               last_grant_q;
  logic               last_grant_d;

  logic               grant_d1_s;
  logic               grant_d2_s;
  logic               can_load_s;
  logic               load_s;

  // Round-robin grant: a lone requester always wins, under contention the
  // source that did not win the last load gets the turn.
  always_comb begin
    grant_d1_s = 1'b0;
    grant_d2_s = 1'b0;
    case ({d1_valid, d2_valid})
      2'b10: begin
        grant_d1_s = 1'b1;
      end
      2'b01: begin
        grant_d2_s = 1'b1;
      end
      2'b11: begin
        if (last_grant_q) begin
          grant_d1_s = 1'b1;
        end else begin
          grant_d2_s = 1'b1;
        end
      end
      default: begin
        grant_d1_s = 1'b0;
        grant_d2_s = 1'b0;
      end
    endcase
  end

  // Space available when empty or when the held word leaves this cycle;
  // rst_n gates the load so no ready is ever shown during reset.
  always_comb begin
    can_load_s = (state_q == ST_EMPTY) | (y_ready & (state_q == ST_FULL));
    load_s     = rst_n & can_load_s & (grant_d1_s | grant_d2_s);
    d1_ready   = rst_n & can_load_s & grant_d1_s;
    d2_ready   = rst_n & can_load_s & grant_d2_s;
  end

  // Next-state and datapath update: capture the winner on a load, otherwise
  // hold y/s and only drop to EMPTY when the held word drains.
  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    s_d          = s_q;
    last_grant_d = last_grant_q;
    if (load_s) begin
      y_d          = grant_d2_s ? d2 : d1;
      s_d          = grant_d2_s;
      last_grant_d = grant_d2_s;
    end else begin
      y_d          = y_q;
      s_d          = s_q;
      last_grant_d = last_grant_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (load_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          state_d = ST_FULL;
        end else if (y_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State register with synchronous active-low reset; last_grant resets to
  // d2 so that d1 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      y_q          <= {WIDTH{1'b0}};
      s_q          <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      s_q          <= s_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs come straight from registers: no path from y_ready to y or s.
  always_comb begin
    y_valid = (state_q == ST_FULL);
    y       = y_q;
    s       = s_q;
  end

endmodule

// File: tb/tb_rr_mux_2x1_arb.sv
// Scoreboard bench for rr_mux_2x1_arb. The stimulus process keeps a
// queue-based model of the output buffer (queue length = occupancy) and a
// "last winner" bit; every accepted source word is pushed as the expected
// output. A separate monitor compares the presented y/s against the queue
// head whenever y_valid is high and pops it on a downstream transfer.
module tb_rr_mux_2x1_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         d1_valid;
  logic [W-1:0] d1;
  logic         d1_ready;
  logic         d2_valid;
  logic [W-1:0] d2;
  logic         d2_ready;
  logic         s;
  logic         y_valid;
  logic [W-1:0] y;
  logic         y_ready;

  always #5 clk = ~clk;

  rr_mux_2x1_arb #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d1_valid (d1_valid),
    .d1       (d1),
    .d1_ready (d1_ready),
    .d2_valid (d2_valid),
    .d2       (d2),
    .d2_ready (d2_ready),
    .s        (s),
    .y_valid  (y_valid),
    .y        (y),
    .y_ready  (y_ready)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         sel;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   in_reset = 1'b1;
  bit   last_winner = 1'b1;
  bit   acc1 = 1'b0;
  bit   acc2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One normal-operation cycle: drive inputs after the falling edge, then
  // check readys and y_valid against the model and record the accepted word.
  task automatic cycle(input bit v1, input logic [W-1:0] a,
                       input bit v2, input logic [W-1:0] b, input bit yr);
    bit occupied;
    bit can_load;
    bit win1;
    bit win2;
    exp_t e;
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    d1_valid = v1;
    d1       = a;
    d2_valid = v2;
    d2       = b;
    y_ready  = yr;
    #1;
    occupied = (exp_q.size() != 0);
    can_load = !occupied || yr;
    win1     = v1 && (!v2 || last_winner);
    win2     = v2 && !win1;
    chk("y_valid", 32'(y_valid), 32'(occupied));
    chk("d1_ready", 32'(d1_ready), 32'(can_load && win1));
    chk("d2_ready", 32'(d2_ready), 32'(can_load && win2));
    acc1 = d1_ready;
    acc2 = d2_ready;
    if (can_load && (win1 || win2)) begin
      e.data = win2 ? b : a;
      e.sel  = win2;
      exp_q.push_back(e);
      last_winner = win2;
    end
  endtask

  // Hold rst_n low for n edges with both sources valid; readys must stay low
  // throughout, and the registers must read as reset after the first edge.
  task automatic do_reset(input int n);
    in_reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n    = 1'b0;
      d1_valid = 1'b1;
      d2_valid = 1'b1;
      d1       = W'($urandom);
      d2       = W'($urandom);
      y_ready  = 1'($urandom);
      #1;
      chk("rst_d1_ready", 32'(d1_ready), 32'(0));
      chk("rst_d2_ready", 32'(d2_ready), 32'(0));
      if (i > 0) begin
        chk("rst_y_valid", 32'(y_valid), 32'(0));
        chk("rst_y", 32'(y), 32'(0));
        chk("rst_s", 32'(s), 32'(0));
      end
    end
    exp_q.delete();
    last_winner = 1'b1;
    acc1 = 1'b0;
    acc2 = 1'b0;
  endtask

  // Monitor: compare every presented word against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (!in_reset && y_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(1), 32'(0));
      end else begin
        chk("y", 32'(y), 32'(exp_q[0].data));
        chk("s", 32'(s), 32'(exp_q[0].sel));
        if (y_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit           v1;
    bit           v2;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n    = 1'b0;
    d1_valid = 1'b0;
    d2_valid = 1'b0;
    d1       = '0;
    d2       = '0;
    y_ready  = 1'b0;

    do_reset(3);

    // single source from d1
    cycle(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // contention at full throughput, starting with d1 after reset
    do_reset(2);
    repeat (6) cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // backpressure with 8'h11 held, then release lets d2 in
    do_reset(2);
    cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    repeat (3) cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // priority memory: d2 alone, then contention goes to d1
    do_reset(2);
    cycle(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
    cycle(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // reset while FULL, then d1 wins first after release
    cycle(1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    do_reset(2);
    cycle(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // randomized traffic; a source keeps its word until it is accepted
    v1 = 1'b0;
    v2 = 1'b0;
    a  = '0;
    b  = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(v1 && !acc1)) begin
        v1 = ($urandom_range(3) != 0);
        a  = W'($urandom);
      end
      if (!(v2 && !acc2)) begin
        v2 = ($urandom_range(3) != 0);
        b  = W'($urandom);
      end
      if ($urandom_range(199) == 0) begin
        do_reset(2);
        v1 = 1'b0;
        v2 = 1'b0;
      end else begin
        cycle(v1, a, v2, b, ($urandom_range(3) != 0));
      end
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
